// File: rtl/pipes_list_rng.sv
// rtl/pipes_list_rng.sv - ordered pipe list with single-pass iterator and bounded LFSR random source
module pipes_list_rng #(
    parameter int CAPACITY      = 8,
    parameter int X_WIDTH       = 12,
    parameter int Y_WIDTH       = 11,
    parameter int RNG_OUT_WIDTH = 9,
    parameter int RNG_OUT_MIN   = 0,
    parameter int RNG_OUT_MAX   = 280
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    output logic [4:0]                 count,
    input  logic                       insert_en,
    input  logic [X_WIDTH+Y_WIDTH-1:0] insert_data,
    input  logic                       iter_start,
    output logic                       iter_done,
    input  logic [X_WIDTH+Y_WIDTH-1:0] iter_in,
    output logic [X_WIDTH+Y_WIDTH-1:0] iter_out,
    input  logic                       iter_remove,
    output logic [RNG_OUT_WIDTH-1:0]   rng_out
);
    localparam int          PW         = X_WIDTH + Y_WIDTH;
    localparam int          RNG_SPAN   = RNG_OUT_MAX - RNG_OUT_MIN + 1;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic {IDLE, ACTIVE} iter_state_e;

    iter_state_e              state_q, state_d;
    logic [4:0]               count_q, count_d;
    logic [4:0]               idx_q, idx_d;
    logic [PW-1:0]            entries_q [CAPACITY];
    logic [PW-1:0]            entries_d [CAPACITY];
    logic [15:0]              lfsr_q, lfsr_d;
    logic [RNG_OUT_WIDTH-1:0] rng_q, rng_d;
    logic                     last;

    function automatic logic [RNG_OUT_WIDTH-1:0] rng_map(input logic [15:0] v);
        logic [31:0] r;
        r = 32'(RNG_OUT_MIN) + (32'(v) % 32'(RNG_SPAN));
        return RNG_OUT_WIDTH'(r);
    endfunction

    // Entries are selected by compare loops rather than dynamic indexing so the
    // 5-bit count/idx never has to be narrowed to the array's index width.
    always_comb begin
        iter_out = '0;
        for (int i = 0; i < CAPACITY; i++) begin
            if (count_q != 5'd0 && 5'(i) == idx_q) begin
                iter_out = entries_q[i];
            end
        end
        last      = (count_q != 5'd0) && (idx_q == count_q - 5'd1);
        iter_done = (count_q == 5'd0) || last;
        count     = count_q;
        rng_out   = rng_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        for (int i = 0; i < CAPACITY; i++) begin
            entries_d[i] = entries_q[i];
        end
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        rng_d  = rng_map(lfsr_d);

        if (iter_start) begin
            idx_d   = 5'd0;
            state_d = (count_q != 5'd0) ? ACTIVE : IDLE;
        end else if (state_q == ACTIVE) begin
            if (iter_remove) begin
                for (int i = 0; i < CAPACITY - 1; i++) begin
                    if (5'(i) >= idx_q && 5'(i + 1) < count_q) begin
                        entries_d[i] = entries_q[i + 1];
                    end
                end
                for (int i = 0; i < CAPACITY; i++) begin
                    if (5'(i) == count_q - 5'd1) begin
                        entries_d[i] = '0;
                    end
                end
                count_d = count_q - 5'd1;
                // idx stays put: the shifted-down successor becomes current.
                if (last) begin
                    state_d = IDLE;
                    idx_d   = 5'd0;
                end
            end else begin
                for (int i = 0; i < CAPACITY; i++) begin
                    if (5'(i) == idx_q) begin
                        entries_d[i] = iter_in;
                    end
                end
                if (last) begin
                    state_d = IDLE;
                    idx_d   = 5'd0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
        end else if (insert_en && count_q < 5'(CAPACITY)) begin
            for (int i = 0; i < CAPACITY; i++) begin
                if (5'(i) == count_q) begin
                    entries_d[i] = insert_data;
                end
            end
            count_d = count_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 5'd0;
            idx_q   <= 5'd0;
            for (int i = 0; i < CAPACITY; i++) begin
                entries_q[i] <= '0;
            end
            lfsr_q  <= LFSR_SEED;
            rng_q   <= rng_map(LFSR_SEED);
        end else if (ce) begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            for (int i = 0; i < CAPACITY; i++) begin
                entries_q[i] <= entries_d[i];
            end
            lfsr_q  <= lfsr_d;
            rng_q   <= rng_d;
        end
    end
endmodule

// File: tb/tb_pipes_list_rng.sv
// tb/tb_pipes_list_rng.sv - queue-model bench for pipes_list_rng with directed vectors
module tb_pipes_list_rng;
    localparam int PW = 23;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic          insert_en = 1'b0;
    logic          iter_start = 1'b0;
    logic          iter_remove = 1'b0;
    logic [PW-1:0] insert_data = '0;
    logic [PW-1:0] iter_in = '0;
    logic [4:0]    count;
    logic          iter_done;
    logic [PW-1:0] iter_out;
    logic [8:0]    rng_out;

    int n_pass = 0;
    int n_total = 0;

    pipes_list_rng dut (
        .clk(clk), .rst(rst), .ce(ce), .count(count),
        .insert_en(insert_en), .insert_data(insert_data),
        .iter_start(iter_start), .iter_done(iter_done),
        .iter_in(iter_in), .iter_out(iter_out),
        .iter_remove(iter_remove), .rng_out(rng_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [PW-1:0] mk(input int x, input int y);
        return {12'(x), 11'(y)};
    endfunction

    function automatic logic [8:0] mmap(input logic [15:0] v);
        return 9'(32'(v) % 281);
    endfunction

    function automatic logic [15:0] mstep(input logic [15:0] v);
        return (v % 2 == 1) ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference: a queue of pipes plus a cursor and the LFSR as a number.
    logic [PW-1:0] mq[$];
    bit            m_active = 0;
    int            m_idx = 0;
    logic [15:0]   m_lfsr = 16'hACE1;
    bit            m_valid = 0;

    always @(posedge clk) begin
        int n;
        n = mq.size();
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_idx    = 0;
            m_lfsr   = 16'hACE1;
            m_valid  = 1;
        end else if (ce && m_valid) begin
            m_lfsr = mstep(m_lfsr);
            if (iter_start) begin
                m_idx    = 0;
                m_active = (n > 0);
            end else if (m_active) begin
                if (!iter_remove) mq[m_idx] = iter_in;
                else mq.delete(m_idx);
                if (m_idx == n - 1) begin
                    m_active = 0;
                    m_idx    = 0;
                end else if (!iter_remove) begin
                    m_idx++;
                end
            end else if (insert_en && n < 8) begin
                mq.push_back(insert_data);
            end
        end
    end

    always @(negedge clk) begin
        int n;
        if (m_valid) begin
            n = mq.size();
            chk("count", 32'(count), 32'(n));
            chk("iter_out", 32'(iter_out), (n == 0) ? 32'd0 : 32'(mq[m_idx]));
            chk("iter_done", 32'(iter_done), 32'((n == 0) || (m_idx == n - 1)));
            chk("rng_out", 32'(rng_out), 32'(mmap(m_lfsr)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic ins(input int x, input int y);
        insert_en   = 1'b1;
        insert_data = mk(x, y);
        step();
        insert_en   = 1'b0;
    endtask

    task automatic start();
        iter_start = 1'b1;
        step();
        iter_start = 1'b0;
    endtask

    int          xs[3] = '{639, 500, 300};
    int          ys[3] = '{100, 50, 7};
    logic [8:0]  seq1[16];
    bit          seen[512];
    int          bad, changes, distinct;
    logic [8:0]  prev;
    logic [8:0]  rng_hold;

    initial begin
        step();
        chk("reset_count", 32'(count), 0);
        chk("reset_done", 32'(iter_done), 1);
        chk("reset_out", 32'(iter_out), 0);
        chk("reset_rng", 32'(rng_out), 140);
        rst = 1'b0;
        step();
        chk("rng_first_step", 32'(rng_out), 82);

        for (int i = 0; i < 3; i++) ins(xs[i], ys[i]);
        chk("count_after_insert", 32'(count), 3);
        start();
        chk("head", 32'(iter_out), 32'(mk(639, 100)));
        chk("head_done", 32'(iter_done), 0);
        for (int i = 0; i < 3; i++) begin
            chk("pass1_done", 32'(iter_done), 32'(i == 2));
            iter_in = mk(xs[i] - 1, ys[i]);
            step();
        end
        iter_in = mk(1, 1);
        step();
        start();
        for (int i = 0; i < 3; i++) begin
            chk("pass2_read", 32'(iter_out), 32'(mk(xs[i] - 1, ys[i])));
            iter_in = mk(xs[i] - 1, ys[i]);
            step();
        end
        chk("pass2_count", 32'(count), 3);
        start();
        insert_en   = 1'b1;
        insert_data = mk(5, 5);
        iter_in     = mk(638, 100);
        step();
        insert_en   = 1'b0;
        chk("insert_while_active", 32'(count), 3);

        do_reset();
        for (int i = 0; i < 3; i++) ins(xs[i], ys[i]);
        start();
        iter_remove = 1'b1;
        step();
        iter_remove = 1'b0;
        chk("remove_first_next", 32'(iter_out), 32'(mk(500, 50)));
        chk("remove_first_count", 32'(count), 2);
        iter_in = mk(500, 50);
        step();
        chk("at_last_done", 32'(iter_done), 1);
        chk("at_last_out", 32'(iter_out), 32'(mk(300, 7)));
        iter_remove = 1'b1;
        step();
        iter_remove = 1'b0;
        chk("remove_last_count", 32'(count), 1);
        iter_in = mk(9, 9);
        step();
        chk("idle_ignores_writeback", 32'(iter_out), 32'(mk(500, 50)));

        do_reset();
        for (int i = 0; i < 3; i++) ins(xs[i], ys[i]);
        start();
        iter_in = mk(639, 100);
        step();
        rng_hold    = mmap(m_lfsr);
        ce          = 1'b0;
        insert_en   = 1'b1;
        iter_remove = 1'b1;
        iter_in     = mk(77, 77);
        for (int i = 0; i < 10; i++) step();
        ce          = 1'b1;
        insert_en   = 1'b0;
        iter_remove = 1'b0;
        chk("ce_hold_out", 32'(iter_out), 32'(mk(500, 50)));
        chk("ce_hold_count", 32'(count), 3);
        chk("ce_hold_rng", 32'(rng_out), 32'(rng_hold));

        do_reset();
        for (int i = 0; i < 9; i++) ins(i * 10 - 50, i);
        chk("full_count", 32'(count), 8);
        start();
        for (int i = 0; i < 8; i++) begin
            chk("full_read", 32'(iter_out), 32'(mk(i * 10 - 50, i)));
            iter_in = mk(i * 10 - 50, i);
            step();
        end

        do_reset();
        start();
        chk("empty_done", 32'(iter_done), 1);
        chk("empty_out", 32'(iter_out), 0);
        iter_in     = mk(7, 7);
        iter_remove = 1'b1;
        step();
        iter_remove = 1'b0;
        chk("empty_count", 32'(count), 0);
        ins(1, 2);
        chk("empty_stays_idle", 32'(count), 1);

        do_reset();
        bad = 0;
        changes = 0;
        distinct = 0;
        prev = rng_out;
        for (int i = 0; i < 10000; i++) begin
            if (i < 16) seq1[i] = rng_out;
            if (rng_out > 9'd280) bad++;
            if (!seen[rng_out]) begin
                seen[rng_out] = 1;
                distinct++;
            end
            if (i > 0 && rng_out != prev) changes++;
            prev = rng_out;
            step();
        end
        chk("rng_range", 32'(bad), 0);
        chk("rng_distinct", 32'(distinct >= 200), 1);
        chk("rng_changes", 32'(changes >= 9000), 1);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk("rng_repeat", 32'(rng_out), 32'(seq1[i]));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipes_list_rng.md
Name: pipes_list_rng

Overview:
- Game-logic storage and random source for the flappy-bird CPU.
- Holds an ordered list of active pipes (oldest first), with tail insert and a single-pass read-modify-write/remove iterator.
- Also provides a pseudo-random pipe-gap height from an LFSR, bounded to a parameterised range.
- Sits beside the CPU state machine; everything advances only when `ce` is high.

Parameters:
- CAPACITY, 8: maximum stored pipes (1..31).
- X_WIDTH, 12: width of the signed pipe x field (two's complement).
- Y_WIDTH, 11: width of the unsigned pipe y (gap top) field.
- RNG_OUT_WIDTH, 9: width of the random value.
- RNG_OUT_MIN, 0: inclusive lower bound of the random value.
- RNG_OUT_MAX, 280: inclusive upper bound of the random value. Must fit RNG_OUT_WIDTH and be at least RNG_OUT_MIN.

Ports:
- clk  in  1  clock; reset `rst`, synchronous, active-high; clock `clk`.
- rst  in  1  synchronous active-high reset.
- ce  in  1  clock enable; when 0 all state holds.
- count  out  5  number of stored pipes.
- insert_en  in  1  append insert_data at the tail.
- insert_data  in  X_WIDTH+Y_WIDTH  pipe {x[MSBs] signed, y[LSBs]}.
- iter_start  in  1  begin iteration at head.
- iter_done  out  1  current element is the last one, or the list is empty.
- iter_in  in  X_WIDTH+Y_WIDTH  write-back value for the current element.
- iter_out  out  X_WIDTH+Y_WIDTH  current element.
- iter_remove  in  1  delete the current element instead of writing it back.
- rng_out  out  RNG_OUT_WIDTH  random value in [RNG_OUT_MIN, RNG_OUT_MAX].

Behaviour:
- Reset: count=0, all entries=0, iterator idle with idx=0, LFSR=16'hACE1, rng_out=registered mapped value of the seed.
- Reset mid-iteration discards the iteration and clears the list.
- Storage: entries[0..CAPACITY-1]; entry 0 is the oldest/head; valid entries are 0..count-1.
- iter_out: combinational entries[idx]; 0 when count==0.
- iter_done: combinational, (count==0) || (idx==count-1).
- Iterator has two states, IDLE and ACTIVE. All updates below occur only on ce=1.
- iter_start=1: idx<=0; go ACTIVE if count>0, else stay IDLE. iter_start overrides any write-back that cycle.
- ACTIVE, iter_start=0, iter_remove=0:
  - entries[idx]<=iter_in.
  - If iter_done, go IDLE and idx<=0; else idx<=idx+1.
- ACTIVE, iter_start=0, iter_remove=1:
  - Shift entries idx+1..count-1 down by one; clear the vacated top slot; count<=count-1.
  - idx unchanged, so iter_out next cycle shows the following element.
  - If the removed element was last (iter_done), go IDLE and idx<=0.
- IDLE: iter_in and iter_remove are ignored.
- Insert:
  - insert_en=1 while IDLE and count<CAPACITY: entries[count]<=insert_data; count<=count+1.
  - Ignored when full.
  - Ignored while ACTIVE or when iter_start=1 in the same cycle.
- x arithmetic is the caller's. Entries store the raw bits, so negative x is preserved.
- RNG:
  - 16-bit Galois LFSR, taps mask 16'hB400; shifts once per ce cycle.
  - rng_out registered: RNG_OUT_MIN + (lfsr[15:0] mod (RNG_OUT_MAX-RNG_OUT_MIN+1)), truncated to RNG_OUT_WIDTH.
  - Modulus is a parameter constant.
  - Value changes every ce cycle; the LFSR never reaches 0.

Test Plan:
- Reset, then insert {x=639,y=100}, {x=500,y=50}, {x=300,y=7} -> count=3; iter_start -> iter_out={639,100}, iter_done=0.
- Iterate 3 elements feeding iter_in=x-1 each cycle -> iter_done=1 on the third. A second pass reads {638,100}, {499,50}, {299,7}; count stays 3; idle after the last.
- With 3 pipes, iter_remove=1 on the first element -> next iter_out={500,50}, count=2. Remove on the last element -> iterator goes idle, count=1.
- Insert 9 times with CAPACITY=8 -> count=8, 9th ignored. Insert pulsed while ACTIVE -> count unchanged. iter_start with count=0 -> iter_done=1, iter_out=0, stays idle.
- Hold ce=0 for 10 cycles during iteration and insert -> outputs, count and rng_out unchanged.
- Run 10000 ce cycles -> every rng_out in [0,280], ≥200 distinct values, no stuck value. After rst, the sequence repeats identically from seed 16'hACE1.
